// File: rtl/mandel_frame_reader_if.sv
// Pixel stream from the frame reader to the VGA pixel writer.
// AXI-style valid/ready handshake carrying colour plus raster coordinates.
interface mandel_frame_reader_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          pixel_valid;
  logic          pixel_ready;
  logic [7:0]    pixel_color;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;

  modport master (
    output pixel_valid,
    output pixel_color,
    output pixel_x,
    output pixel_y,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_color,
    input  pixel_x,
    input  pixel_y,
    output pixel_ready
  );
endinterface

// File: rtl/mandel_frame_reader.sv
// Raster-order read-back of the partitioned Mandelbrot memories into a
// valid/ready pixel stream, sustaining one pixel per clock when unstalled.
module mandel_frame_reader #(
  parameter int unsigned H_RES          = 640,
  parameter int unsigned V_RES          = 480,
  parameter int unsigned PARTITION      = 2,
  parameter int unsigned PARTITION_SIZE = H_RES * V_RES / PARTITION,
  parameter int unsigned READ_LATENCY   = 1,
  localparam int unsigned AW = (PARTITION_SIZE > 1) ? $clog2(PARTITION_SIZE) : 1,
  localparam int unsigned PW = (PARTITION > 1) ? $clog2(PARTITION) : 1,
  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iter_done,
  output logic [AW-1:0]          m10k_read_address,
  output logic [PW-1:0]          partition_index,
  input  logic [7:0]             vga_data,
  mandel_frame_reader_if.master  pix,
  output logic                   frame_active,
  output logic [15:0]            frame_count
);

  localparam int unsigned LAT   = READ_LATENCY;
  localparam int unsigned DEPTH = READ_LATENCY + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [XW-1:0]             issue_x_q, issue_x_d;
  logic [YW-1:0]             issue_y_q, issue_y_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [PW-1:0]             part_q, part_d;

  logic [LAT-1:0]            dl_valid_q, dl_valid_d;
  logic [LAT-1:0][XW-1:0]    dl_x_q, dl_x_d;
  logic [LAT-1:0][YW-1:0]    dl_y_q, dl_y_d;

  logic [DEPTH-1:0][7:0]     fifo_col_q, fifo_col_d;
  logic [DEPTH-1:0][XW-1:0]  fifo_x_q, fifo_x_d;
  logic [DEPTH-1:0][YW-1:0]  fifo_y_q, fifo_y_d;
  logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;

  logic                      pixel_valid_q, pixel_valid_d;
  logic                      frame_active_q, frame_active_d;
  logic [15:0]               frame_count_q, frame_count_d;

  logic [SW-1:0]             in_flight_c;
  logic [SW-1:0]             occupancy_c;
  logic [CW-1:0]             wr_slot_c;
  logic                      issue_c;
  logic                      pop_c;
  logic                      push_c;
  logic                      last_pixel_c;

  always_comb begin
    state_d        = state_q;
    issue_x_d      = issue_x_q;
    issue_y_d      = issue_y_q;
    addr_d         = addr_q;
    part_d         = part_q;
    dl_valid_d     = dl_valid_q;
    dl_x_d         = dl_x_q;
    dl_y_d         = dl_y_q;
    fifo_col_d     = fifo_col_q;
    fifo_x_d       = fifo_x_q;
    fifo_y_d       = fifo_y_q;
    fifo_cnt_d     = fifo_cnt_q;
    pixel_valid_d  = pixel_valid_q;
    frame_active_d = frame_active_q;
    frame_count_d  = frame_count_q;
    in_flight_c    = '0;
    wr_slot_c      = fifo_cnt_q;

    for (int i = 0; i < int'(LAT); i++) begin
      in_flight_c = in_flight_c + SW'(dl_valid_q[i]);
    end

    pop_c  = pixel_valid_q && pix.pixel_ready;
    push_c = dl_valid_q[LAT-1];

    // A same-cycle pop frees its slot for the read being considered now.
    occupancy_c  = SW'(fifo_cnt_q) + in_flight_c - SW'(pop_c);
    issue_c      = (state_q == SCAN) && (occupancy_c < SW'(DEPTH));
    last_pixel_c = (issue_x_q == XW'(H_RES - 1)) && (issue_y_q == YW'(V_RES - 1));

    unique case (state_q)
      IDLE: begin
        if (iter_done) begin
          state_d        = SCAN;
          issue_x_d      = '0;
          issue_y_d      = '0;
          addr_d         = '0;
          part_d         = '0;
          frame_active_d = 1'b1;
        end
      end

      SCAN: begin
        if (issue_c) begin
          if (last_pixel_c) begin
            state_d   = DRAIN;
            issue_x_d = '0;
            issue_y_d = '0;
            addr_d    = '0;
            part_d    = '0;
          end else begin
            if (part_q == PW'(PARTITION - 1)) begin
              part_d = '0;
              addr_d = addr_q + AW'(1);
            end else begin
              part_d = part_q + PW'(1);
            end
            if (issue_x_q == XW'(H_RES - 1)) begin
              issue_x_d = '0;
              issue_y_d = issue_y_q + YW'(1);
            end else begin
              issue_x_d = issue_x_q + XW'(1);
            end
          end
        end
      end

      DRAIN: begin
        if ((in_flight_c == '0) && (fifo_cnt_q == '0)) begin
          state_d        = IDLE;
          frame_active_d = 1'b0;
          frame_count_d  = frame_count_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Coordinates ride alongside the memory access so colour and position stay paired.
    for (int i = int'(LAT) - 1; i >= 1; i--) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_x_d[i]     = dl_x_q[i-1];
      dl_y_d[i]     = dl_y_q[i-1];
    end
    dl_valid_d[0] = issue_c;
    dl_x_d[0]     = issue_x_q;
    dl_y_d[0]     = issue_y_q;

    // Shifting FIFO: entry 0 is always the head, so outputs come straight from flops.
    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_col_d[i] = fifo_col_q[i+1];
        fifo_x_d[i]   = fifo_x_q[i+1];
        fifo_y_d[i]   = fifo_y_q[i+1];
      end
      wr_slot_c = fifo_cnt_q - CW'(1);
    end
    if (push_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_slot_c) begin
          fifo_col_d[i] = vga_data;
          fifo_x_d[i]   = dl_x_q[LAT-1];
          fifo_y_d[i]   = dl_y_q[LAT-1];
        end
      end
    end
    fifo_cnt_d    = fifo_cnt_q - CW'(pop_c) + CW'(push_c);
    pixel_valid_d = (fifo_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      issue_x_q      <= '0;
      issue_y_q      <= '0;
      addr_q         <= '0;
      part_q         <= '0;
      dl_valid_q     <= '0;
      dl_x_q         <= '0;
      dl_y_q         <= '0;
      fifo_col_q     <= '0;
      fifo_x_q       <= '0;
      fifo_y_q       <= '0;
      fifo_cnt_q     <= '0;
      pixel_valid_q  <= 1'b0;
      frame_active_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      issue_x_q      <= issue_x_d;
      issue_y_q      <= issue_y_d;
      addr_q         <= addr_d;
      part_q         <= part_d;
      dl_valid_q     <= dl_valid_d;
      dl_x_q         <= dl_x_d;
      dl_y_q         <= dl_y_d;
      fifo_col_q     <= fifo_col_d;
      fifo_x_q       <= fifo_x_d;
      fifo_y_q       <= fifo_y_d;
      fifo_cnt_q     <= fifo_cnt_d;
      pixel_valid_q  <= pixel_valid_d;
      frame_active_q <= frame_active_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign m10k_read_address = addr_q;
  assign partition_index   = part_q;
  assign pix.pixel_valid   = pixel_valid_q;
  assign pix.pixel_color   = fifo_col_q[0];
  assign pix.pixel_x       = fifo_x_q[0];
  assign pix.pixel_y       = fifo_y_q[0];
  assign frame_active      = frame_active_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_mandel_frame_reader.sv
// Bench for mandel_frame_reader: two configurations (4x2/P2/L1 and 8x3/P4/L3)
// checked every cycle against a raster-order pixel model.
module tb_mandel_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic iter_done_a, iter_done_b;

  logic [1:0]  addr_a;
  logic [0:0]  part_a;
  logic [7:0]  vga_a;
  logic        fa_a;
  logic [15:0] fc_a;

  logic [2:0]  addr_b;
  logic [1:0]  part_b;
  logic [7:0]  vga_b;
  logic        fa_b;
  logic [15:0] fc_b;

  mandel_frame_reader_if #(.XW(2), .YW(1)) pix_a ();
  mandel_frame_reader_if #(.XW(3), .YW(2)) pix_b ();

  mandel_frame_reader #(
    .H_RES(4), .V_RES(2), .PARTITION(2), .PARTITION_SIZE(4), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset(reset), .iter_done(iter_done_a),
    .m10k_read_address(addr_a), .partition_index(part_a), .vga_data(vga_a),
    .pix(pix_a.master), .frame_active(fa_a), .frame_count(fc_a)
  );

  mandel_frame_reader #(
    .H_RES(8), .V_RES(3), .PARTITION(4), .PARTITION_SIZE(6), .READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(reset), .iter_done(iter_done_b),
    .m10k_read_address(addr_b), .partition_index(part_b), .vga_data(vga_b),
    .pix(pix_b.master), .frame_active(fa_b), .frame_count(fc_b)
  );

  // Memory models: word = {partition, address}, returned after the read latency.
  logic [7:0] mem_a_q;
  logic [7:0] mem_b_q [3];
  always @(posedge clk) begin
    mem_a_q    <= 8'(32'(part_a) * 64 + 32'(addr_a));
    mem_b_q[0] <= 8'(32'(part_b) * 64 + 32'(addr_b));
    mem_b_q[1] <= mem_b_q[0];
    mem_b_q[2] <= mem_b_q[1];
  end
  assign vga_a = mem_a_q;
  assign vga_b = mem_b_q[2];

  int total, bad;
  int idx [2];
  int frames [2];
  int accepted [2];
  int last_col [2];
  bit prev_stall [2];
  int ready_mode [2];
  int ph;

  function automatic int hres_of(int c); return (c == 0) ? 4 : 8; endfunction
  function automatic int vres_of(int c); return (c == 0) ? 2 : 3; endfunction
  function automatic int npart_of(int c); return (c == 0) ? 2 : 4; endfunction

  function automatic int exp_col(int c, int x, int y);
    int p, a;
    p = x % npart_of(c);
    a = y * (hres_of(c) / npart_of(c)) + x / npart_of(c);
    return (p * 64 + a) % 256;
  endfunction

  function automatic logic ready_for(int mode, int p);
    case (mode)
      0: return 1'b1;
      1: return !((p % 4 == 1) || (p % 4 == 2));
      2: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic fa_of(int c);
    return (c == 0) ? fa_a : fa_b;
  endfunction

  task automatic expect_eq(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      idx[c]        = 0;
      frames[c]     = 0;
      prev_stall[c] = 1'b0;
    end
  endtask

  task automatic check_cfg(int c, logic v, logic r, int col, int x, int y, logic fa, int fc);
    int ex, ey;
    ex = idx[c] % hres_of(c);
    ey = idx[c] / hres_of(c);
    if (prev_stall[c]) begin
      total++;
      if (!v) begin
        bad++;
        $display("FAIL hold%0d: pixel_valid dropped while stalled at t=%0t", c, $time);
      end
    end
    if (v) begin
      total++;
      if (x != ex || y != ey || col != exp_col(c, ex, ey)) begin
        bad++;
        $display("FAIL pix%0d: got x=%0d y=%0d col=%0d expected x=%0d y=%0d col=%0d",
                 c, x, y, col, ex, ey, exp_col(c, ex, ey));
      end
      if (r) begin
        accepted[c]++;
        last_col[c] = col;
        idx[c]++;
        if (idx[c] == hres_of(c) * vres_of(c)) begin
          idx[c] = 0;
          frames[c]++;
        end
      end
    end
    if (!fa) begin
      total++;
      if (fc != frames[c] || v) begin
        bad++;
        $display("FAIL idle%0d: got frame_count=%0d valid=%0d expected frame_count=%0d valid=0",
                 c, fc, v, frames[c]);
      end
    end
    prev_stall[c] = v && !r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    pix_a.pixel_ready = ready_for(ready_mode[0], ph);
    pix_b.pixel_ready = ready_for(ready_mode[1], ph);
    check_cfg(0, pix_a.pixel_valid, pix_a.pixel_ready, int'(pix_a.pixel_color),
              int'(pix_a.pixel_x), int'(pix_a.pixel_y), fa_a, int'(fc_a));
    check_cfg(1, pix_b.pixel_valid, pix_b.pixel_ready, int'(pix_b.pixel_color),
              int'(pix_b.pixel_x), int'(pix_b.pixel_y), fa_b, int'(fc_b));
  endtask

  task automatic wait_frames(int c, int n, int budget);
    int k;
    k = 0;
    while (!(frames[c] >= n && !fa_of(c)) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL timeout%0d: frames=%0d expected %0d", c, frames[c], n);
    end
  endtask

  initial begin
    int a0, b0, f0, f1, base, low, k;
    bit started;
    int t1_addr [8];
    int t1_part [8];
    int t6_addr [5];
    int t6_part [5];
    t1_addr = '{0, 0, 1, 1, 2, 2, 3, 3};
    t1_part = '{0, 1, 0, 1, 0, 1, 0, 1};
    t6_addr = '{0, 0, 0, 0, 1};
    t6_part = '{0, 1, 2, 3, 0};

    total = 0; bad = 0; ph = 0;
    for (int c = 0; c < 2; c++) begin
      accepted[c] = 0; last_col[c] = 0; ready_mode[c] = 0;
    end
    iter_done_a = 1'b0; iter_done_b = 1'b0;
    pix_a.pixel_ready = 1'b0; pix_b.pixel_ready = 1'b0;

    reset = 1'b1;
    model_reset();
    tick();
    tick();
    expect_eq("rst_addr_a", int'(addr_a), 0);
    expect_eq("rst_part_a", int'(part_a), 0);
    expect_eq("rst_valid_a", int'(pix_a.pixel_valid), 0);
    expect_eq("rst_active_a", int'(fa_a), 0);
    expect_eq("rst_addr_b", int'(addr_b), 0);
    expect_eq("rst_part_b", int'(part_b), 0);
    reset = 1'b0;
    tick();

    // Single frame, no backpressure: address/partition order and latency.
    a0 = accepted[0];
    iter_done_a = 1'b1;
    tick();
    iter_done_a = 1'b0;
    expect_eq("t1_active", int'(fa_a), 1);
    for (int i = 0; i < 8; i++) begin
      expect_eq($sformatf("t1_addr%0d", i), int'(addr_a), t1_addr[i]);
      expect_eq($sformatf("t1_part%0d", i), int'(part_a), t1_part[i]);
      if (i == 1) expect_eq("t1_lat_lo", int'(pix_a.pixel_valid), 0);
      if (i == 2) expect_eq("t1_lat_hi", int'(pix_a.pixel_valid), 1);
      tick();
    end
    tick();
    expect_eq("t1_count", accepted[0] - a0, 8);
    expect_eq("t1_last_col", last_col[0], 67);
    wait_frames(0, 1, 50);
    expect_eq("t1_frames", int'(fc_a), 1);

    // Ready pattern 1,0,0,1.
    ready_mode[0] = 1;
    a0 = accepted[0];
    iter_done_a = 1'b1;
    tick();
    iter_done_a = 1'b0;
    wait_frames(0, 2, 120);
    expect_eq("t2_count", accepted[0] - a0, 8);
    expect_eq("t2_frames", int'(fc_a), 2);

    // Three back-to-back frames with iter_done held.
    ready_mode[0] = 0;
    base = frames[0];
    a0 = accepted[0];
    low = 0;
    started = 1'b0;
    iter_done_a = 1'b1;
    k = 0;
    while (!(frames[0] >= base + 3 && !fa_a) && k < 200) begin
      tick();
      k++;
      if (accepted[0] - a0 >= 17) iter_done_a = 1'b0;
      if (fa_a) started = 1'b1;
      if (started && !fa_a && frames[0] < base + 3) low++;
    end
    iter_done_a = 1'b0;
    expect_eq("t3_timeout", int'(k < 200), 1);
    expect_eq("t3_gap_cycles", low, 2);
    expect_eq("t3_count", accepted[0] - a0, 24);
    expect_eq("t3_frames", int'(fc_a), base + 3);

    // iter_done dropped mid-scan: frame finishes, then stays idle.
    base = frames[0];
    a0 = accepted[0];
    iter_done_a = 1'b1;
    k = 0;
    while (!(frames[0] >= base + 1 && !fa_a) && k < 60) begin
      tick();
      k++;
      if (accepted[0] - a0 >= 3) iter_done_a = 1'b0;
    end
    iter_done_a = 1'b0;
    expect_eq("t4_timeout", int'(k < 60), 1);
    expect_eq("t4_count", accepted[0] - a0, 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_eq("t4_stay_idle", int'(fa_a), 0);
    end

    // Reset with reads buffered.
    ready_mode[0] = 3;
    iter_done_a = 1'b1;
    tick();
    iter_done_a = 1'b0;
    tick();
    tick();
    tick();
    expect_eq("t5_buffered", int'(pix_a.pixel_valid), 1);
    reset = 1'b1;
    model_reset();
    tick();
    expect_eq("t5_valid", int'(pix_a.pixel_valid), 0);
    expect_eq("t5_addr", int'(addr_a), 0);
    expect_eq("t5_part", int'(part_a), 0);
    expect_eq("t5_frames", int'(fc_a), 0);
    reset = 1'b0;
    ready_mode[0] = 0;
    tick();
    tick();
    a0 = accepted[0];
    iter_done_a = 1'b1;
    tick();
    iter_done_a = 1'b0;
    expect_eq("t5_restart_addr", int'(addr_a), 0);
    expect_eq("t5_restart_part", int'(part_a), 0);
    wait_frames(0, 1, 50);
    expect_eq("t5_count", accepted[0] - a0, 8);

    // Wide config: latency 3, four partitions, sustained rate.
    b0 = accepted[1];
    iter_done_b = 1'b1;
    tick();
    iter_done_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_eq($sformatf("t6_part%0d", i), int'(part_b), t6_part[i]);
      expect_eq($sformatf("t6_addr%0d", i), int'(addr_b), t6_addr[i]);
      if (i == 3) expect_eq("t6_lat_lo", int'(pix_b.pixel_valid), 0);
      if (i == 4) expect_eq("t6_lat_hi", int'(pix_b.pixel_valid), 1);
      tick();
    end
    repeat (22) tick();
    expect_eq("t6_rate", accepted[1] - b0, 24);
    expect_eq("t6_last_col", last_col[1], 197);
    wait_frames(1, 1, 60);
    expect_eq("t6_frames", int'(fc_b), 1);

    // Random backpressure on both configurations.
    for (int r = 0; r < 4; r++) begin
      ready_mode[0] = (r % 2 == 0) ? 2 : 1;
      ready_mode[1] = 2;
      a0 = accepted[0];
      b0 = accepted[1];
      f0 = frames[0];
      f1 = frames[1];
      iter_done_a = 1'b1;
      iter_done_b = 1'b1;
      tick();
      iter_done_a = 1'b0;
      iter_done_b = 1'b0;
      k = 0;
      while (!(frames[0] > f0 && frames[1] > f1 && !fa_a && !fa_b) && k < 600) begin
        tick();
        k++;
      end
      expect_eq("t7_timeout", int'(k < 600), 1);
      expect_eq("t7_count_a", accepted[0] - a0, 8);
      expect_eq("t7_count_b", accepted[1] - b0, 24);
      expect_eq("t7_frames_a", int'(fc_a), f0 + 1);
      expect_eq("t7_frames_b", int'(fc_b), f1 + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
